// File: rtl/sensor_sched_pkg.sv
// Shared types and constants for the sensor scan scheduler and its arbiter.
package sensor_sched_pkg;

    localparam int NCH    = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 8;

    localparam logic [7:0] ALARM_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SETTLE,
        SAMPLE
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ALARM_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: picks the first requester after i_last.
module rr_arbiter4
    import sensor_sched_pkg::*;
(
    input  logic [NCH-1:0]  i_req,
    input  logic [CH_W-1:0] i_last,
    output logic [NCH-1:0]  o_grant,
    output logic [CH_W-1:0] o_idx,
    output logic            o_any
);

    logic [CH_W-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        // Offsets 1..NCH wrap back to i_last itself, so the last winner has lowest priority.
        for (int i = 1; i <= NCH; i++) begin
            w_cand = i_last + CH_W'(i);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_scan_scheduler.sv
// Scan scheduler: ticks, round-robin grants one sensor sample into the change
// detector, waits for its result to settle, then records alarms and events.
module sensor_scan_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int SETTLE_CYC = 3,
    parameter int PERIOD_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [3:0]          req_valid,
    input  logic [31:0]         req_data,
    output logic [3:0]          req_ready,
    output logic [7:0]          cop_r0,
    output logic [1:0]          cop_check,
    input  logic                cop_q,
    input  logic [1:0]          cop_q1,
    input  logic [3:0]          alarm_clr,
    output logic [3:0]          alarm_flags,
    output logic [7:0]          alarm_cnt,
    output logic                evt_valid,
    output logic                evt_alarm,
    output logic [1:0]          evt_ch,
    output logic                busy
);

    state_t              r_state;
    logic [PERIOD_W-1:0] r_tick_cnt;
    logic                r_tick_pend;
    logic [CH_W-1:0]     r_ptr;
    logic [CH_W-1:0]     r_sel;
    logic [3:0]          r_settle_cnt;
    logic [NCH-1:0]      r_req_ready;
    logic [DATA_W-1:0]   r_cop_r0;
    logic [CH_W-1:0]     r_cop_check;
    logic [NCH-1:0]      r_alarm_flags;
    logic [7:0]          r_alarm_cnt;
    logic                r_evt_valid;
    logic                r_evt_alarm;
    logic [CH_W-1:0]     r_evt_ch;
    logic                r_busy;

    logic                w_tick;
    logic                w_start;
    logic [NCH-1:0]      w_arb_grant;
    logic [CH_W-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic [NCH-1:0]      w_set_mask;
    logic                w_echo_unused;

    rr_arbiter4 u_arb (
        .i_req   (req_valid),
        .i_last  (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign w_tick     = en && (r_tick_cnt == '0);
    assign w_start    = en && (w_tick || r_tick_pend) && w_arb_any;
    assign w_set_mask = (r_state == SAMPLE && cop_q) ? (NCH'(1) << r_sel) : '0;
    // The detector's channel echo is not trusted; the registered sel decides the channel.
    assign w_echo_unused = ^cop_q1;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (en) begin
            r_tick_cnt <= w_tick ? period : r_tick_cnt - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_tick_pend   <= 1'b0;
            r_ptr         <= CH_W'(NCH - 1);
            r_sel         <= '0;
            r_settle_cnt  <= '0;
            r_req_ready   <= '0;
            r_cop_r0      <= '0;
            r_cop_check   <= '0;
            r_alarm_flags <= '0;
            r_alarm_cnt   <= '0;
            r_evt_valid   <= 1'b0;
            r_evt_alarm   <= 1'b0;
            r_evt_ch      <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_evt_valid   <= 1'b0;
            r_evt_alarm   <= 1'b0;
            r_evt_ch      <= '0;
            // A set in SAMPLE wins over a clear landing in the same cycle.
            r_alarm_flags <= (r_alarm_flags & ~alarm_clr) | w_set_mask;

            case (r_state)
                IDLE: begin
                    r_tick_pend <= 1'b0;
                    if (w_start) begin
                        r_state     <= GRANT;
                        r_sel       <= w_arb_idx;
                        r_req_ready <= w_arb_grant;
                        r_busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    r_req_ready  <= '0;
                    r_cop_r0     <= req_data[r_sel*DATA_W +: DATA_W];
                    r_cop_check  <= r_sel;
                    r_ptr        <= r_sel;
                    r_settle_cnt <= 4'(SETTLE_CYC - 1);
                    r_state      <= SETTLE;
                    if (!en)         r_tick_pend <= 1'b0;
                    else if (w_tick) r_tick_pend <= 1'b1;
                end
                SETTLE: begin
                    if (!en)         r_tick_pend <= 1'b0;
                    else if (w_tick) r_tick_pend <= 1'b1;
                    if (r_settle_cnt == '0) r_state <= SAMPLE;
                    else                    r_settle_cnt <= r_settle_cnt - 4'd1;
                end
                SAMPLE: begin
                    r_evt_valid <= 1'b1;
                    r_evt_alarm <= cop_q;
                    r_evt_ch    <= r_sel;
                    if (cop_q) r_alarm_cnt <= sat_inc(r_alarm_cnt);
                    // Passing through IDLE takes no cycle, so back-to-back scans stay SETTLE_CYC+2 apart.
                    r_tick_pend <= 1'b0;
                    if (w_start) begin
                        r_state     <= GRANT;
                        r_sel       <= w_arb_idx;
                        r_req_ready <= w_arb_grant;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign cop_r0      = r_cop_r0;
    assign cop_check   = r_cop_check;
    assign alarm_flags = r_alarm_flags;
    assign alarm_cnt   = r_alarm_cnt;
    assign evt_valid   = r_evt_valid;
    assign evt_alarm   = r_evt_alarm;
    assign evt_ch      = r_evt_ch;
    assign busy        = r_busy;

endmodule
